esp_cmd_seq: RTL and testbench
==============================

# esp_cmd_seq

Parametrised AT-command sequencer for the ESP32 PMOD link. It streams a null-terminated script of LF-terminated commands from a synchronous ROM into the byte-stream TX port of the PMOD UART. After each command it waits for `OK\r\n` or `ERROR\r\n`, and retries on error or timeout. It replaces the single-shot ROM/PC controller and sits between the script ROM and `UART_COM`.

## Interface
Parameters:
- `ADDR_WIDTH`, 7: ROM address width; the script is at most 2^ADDR_WIDTH bytes.
- `TIMEOUT_CYC`, 100_000_000: clock cycles allowed in WAIT_RESP before a retry.
- `MAX_RETRY`, 3: retries per command before FAIL; 0 means no retry.
- `CNT_WIDTH`, 8: width of `cmd_idx`.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse; begins the script at address 0. Ignored while `busy`.
- `rom_addr` out ADDR_WIDTH: script ROM address.
- `rom_data` in 8: ROM byte, valid one cycle after `rom_addr`.
- `tx_data` out 8, `tx_valid` out 1, `tx_ready` in 1: byte stream to the UART TX.
- `rx_data` in 8, `rx_valid` in 1, `rx_ready` out 1: byte stream from the UART RX.
- `mon_data` out 8, `mon_valid` out 1: echo of received bytes. Present only when `ESP_SEQ_MON_EN` is defined.
- `busy` out 1: high from the accepted `start` until DONE or FAIL.
- `done` out 1: one-cycle pulse on script completion.
- `error` out 1: sticky; set on FAIL, cleared by the next accepted `start`.
- `cmd_idx` out CNT_WIDTH: index of the current command, 0-based.

## Operation
- States: IDLE, FETCH, LOAD, SEND, WAIT_RESP, DONE, FAIL.
- IDLE: on `start`, set `rom_addr`=0, `cmd_base`=0, `cmd_idx`=0, retry counter=0, clear `error`, go to FETCH.
- FETCH: one bubble cycle for ROM latency, then go to LOAD.
- LOAD: sample `rom_data`.
  - If the byte is 0x00 and it is the first byte of a command, go to DONE.
  - Otherwise register it into `tx_data`, assert `tx_valid`, go to SEND.
- SEND: hold `tx_data` and `tx_valid` until `tx_ready`.
  - On the handshake, increment `rom_addr`.
  - If the sent byte was 0x0A, go to WAIT_RESP; otherwise go to FETCH.
- WAIT_RESP:
  - Shift each accepted rx byte into a 32-bit history register.
  - History == 0x4F4B0D0A (`OK\r\n`) is success: `cmd_idx`++, `cmd_base`=`rom_addr`, retry counter=0, go to FETCH.
  - History == 0x4F520D0A (tail of `ERROR\r\n`), or timeout counter == TIMEOUT_CYC-1, is a failure.
  - On failure: if retry counter < MAX_RETRY, increment it, set `rom_addr`=`cmd_base`, go to FETCH. Otherwise go to FAIL.
- DONE: pulse `done`, return to IDLE. FAIL: set `error`, return to IDLE.
- The history register and timeout counter clear on every entry to FETCH from IDLE or WAIT_RESP, so command echo bytes do not carry across commands.
- `rx_ready` is held at 1 in all states. Bytes arriving outside WAIT_RESP are dropped, but still echoed on `mon_*`.
- `rom_addr` wraps modulo 2^ADDR_WIDTH. A script with no terminator loops; this is the integrator's responsibility.

## Timing
- Reset values: `tx_valid`=0, `tx_data`=0, `rom_addr`=0, `busy`=0, `done`=0, `error`=0, `cmd_idx`=0, `mon_valid`=0, `mon_data`=0. `rx_ready`=1 during and after reset.
- Reset asserted mid-operation drops `tx_valid` on the next edge, even mid-handshake, and returns to IDLE.
- Per-byte cost is 3 cycles minimum (FETCH, LOAD, SEND) with `tx_ready` held high.
- `start` to first `tx_valid`: 2 cycles.
- Success or failure is decided in the cycle after the terminating rx byte is accepted. `rom_addr` is updated on that same edge.
- Match and timeout in the same cycle: match wins.
- `start` in the same cycle as `done`: ignored; `busy` is still high.
- With `ESP_SEQ_MON_EN`, `mon_valid` pulses one cycle after each `rx_valid`, and `mon_data` is registered.

## Configuration
- `ESP_SEQ_MON_EN` defined: the `mon_data`/`mon_valid` ports and their registers exist and echo every received byte, for driving `UART_MON` toward the host.
- Not defined: the ports and logic are removed, and the sequencer behaves identically otherwise.

## Test plan
- Script "AT\r\n\0", `tx_ready`=1, rx returns "AT\r\nOK\r\n" → bytes 0x41 0x54 0x0D 0x0A sent, one `done` pulse, `cmd_idx`=1, `error`=0.
- Two-command script, first reply "ERROR\r\n" then "OK\r\n", MAX_RETRY=3 → first command sent twice, then second command sent, `done` pulses.
- TIMEOUT_CYC=50, no rx ever, MAX_RETRY=2 → command sent 3 times, each 50 cycles apart in WAIT_RESP, then `error`=1, `busy`=0, no `done`.
- `tx_ready` stalled 10 cycles on byte 2 → `tx_data` and `tx_valid` stable throughout, byte order intact.
- `rst` pulsed during SEND → next cycle `tx_valid`=0, `rom_addr`=0, `busy`=0. A fresh `start` replays from address 0.
- Build with and without `ESP_SEQ_MON_EN` → rx byte 0x4F yields `mon_valid` one cycle later with `mon_data`=0x4F. Sequencer output traces are identical between the two builds.

Source files
------------

// File: rtl/esp_cmd_seq.sv
// esp_cmd_seq: streams an LF-terminated AT script from ROM to the UART,
// waits for OK/ERROR, retries. Define ESP_SEQ_MON_EN for the rx echo port.
module esp_cmd_seq #(
    parameter int ADDR_WIDTH  = 7,
    parameter int TIMEOUT_CYC = 100_000_000,
    parameter int MAX_RETRY   = 3,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [7:0]            rom_data,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
`ifdef ESP_SEQ_MON_EN
    output logic [7:0]            mon_data,
    output logic                  mon_valid,
`endif
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [CNT_WIDTH-1:0]  cmd_idx
);

    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam int RW = $clog2(MAX_RETRY + 1) + 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
    localparam logic [31:0] HIST_OK  = 32'h4F4B0D0A;
    localparam logic [31:0] HIST_ERR = 32'h4F520D0A;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_SEND, S_WAIT, S_DONE, S_FAIL
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [CNT_WIDTH-1:0]  idx_q, idx_d;
    logic [RW-1:0]         retry_q, retry_d;
    logic [31:0]           hist_q, hist_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic [7:0]            txd_q, txd_d;
    logic                  txv_q, txv_d;
    logic                  err_q, err_d;

    // Next-state and datapath updates for the sequencer
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        base_d  = base_q;
        idx_d   = idx_q;
        retry_d = retry_q;
        hist_d  = hist_q;
        tmo_d   = tmo_q;
        txd_d   = txd_q;
        txv_d   = txv_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d  = '0;
                    base_d  = '0;
                    idx_d   = '0;
                    retry_d = '0;
                    err_d   = 1'b0;
                    hist_d  = '0;
                    tmo_d   = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                if (rom_data == 8'h00 && addr_q == base_q) begin
                    state_d = S_DONE;
                end else begin
                    txd_d   = rom_data;
                    txv_d   = 1'b1;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (tx_ready) begin
                    txv_d   = 1'b0;
                    addr_d  = addr_q + ADDR_WIDTH'(1);
                    state_d = (txd_q == 8'h0A) ? S_WAIT : S_FETCH;
                end
            end
            S_WAIT: begin
                if (rx_valid) hist_d = {hist_q[23:0], rx_data};
                tmo_d = tmo_q + TW'(1);
                if (hist_q == HIST_OK) begin
                    idx_d   = idx_q + CNT_WIDTH'(1);
                    base_d  = addr_q;
                    retry_d = '0;
                    hist_d  = '0;
                    tmo_d   = '0;
                    state_d = S_FETCH;
                end else if (hist_q == HIST_ERR || tmo_q == TMO_LAST) begin
                    hist_d = '0;
                    tmo_d  = '0;
                    if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + RW'(1);
                        addr_d  = base_q;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_FAIL;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            S_FAIL: begin
                err_d   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            base_q  <= '0;
            idx_q   <= '0;
            retry_q <= '0;
            hist_q  <= '0;
            tmo_q   <= '0;
            txd_q   <= '0;
            txv_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            base_q  <= base_d;
            idx_q   <= idx_d;
            retry_q <= retry_d;
            hist_q  <= hist_d;
            tmo_q   <= tmo_d;
            txd_q   <= txd_d;
            txv_q   <= txv_d;
            err_q   <= err_d;
        end
    end

`ifdef ESP_SEQ_MON_EN
    // Registered echo of every received byte toward the host monitor
    always_ff @(posedge clk) begin
        if (rst) begin
            mon_valid <= 1'b0;
            mon_data  <= '0;
        end else begin
            mon_valid <= rx_valid;
            if (rx_valid) mon_data <= rx_data;
        end
    end
`endif

    assign rom_addr = addr_q;
    assign tx_data  = txd_q;
    assign tx_valid = txv_q;
    assign rx_ready = 1'b1;
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign error    = err_q;
    assign cmd_idx  = idx_q;

endmodule

// File: tb/tb_esp_cmd_seq.sv
// tb_esp_cmd_seq: randomized script/response bench for esp_cmd_seq
// against a command-level model of the retry protocol.
module tb_esp_cmd_seq;

    localparam int AW  = 7;
    localparam int TMO = 50;
    localparam int MR  = 2;
    localparam int CW  = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] rom_addr;
    logic [7:0]    rom_data;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
`ifdef ESP_SEQ_MON_EN
    logic [7:0]    mon_data;
    logic          mon_valid;
`endif
    logic          busy;
    logic          done;
    logic          error;
    logic [CW-1:0] cmd_idx;

    esp_cmd_seq #(
        .ADDR_WIDTH (AW),
        .TIMEOUT_CYC(TMO),
        .MAX_RETRY  (MR),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
`ifdef ESP_SEQ_MON_EN
        .mon_data (mon_data),
        .mon_valid(mon_valid),
`endif
        .busy     (busy),
        .done     (done),
        .error    (error),
        .cmd_idx  (cmd_idx)
    );

    always #5 clk = ~clk;

    logic [7:0] rom [0:(1<<AW)-1];

    always @(posedge clk) rom_data <= rom[rom_addr];

    int         errors = 0;
    int         checks = 0;
    logic [7:0] sent[$];
    logic [7:0] exp_sent[$];
    int         resp_q[$];
    int         gap_q[$];
    int         done_cnt = 0;
    int         nl_pend = 0;
    int         nl_cyc = 0;
    int         cyc = 0;
    bit         rise_wait = 0;
    bit         rnd_ready = 0;
    bit         force_low = 0;
    int         stall_at = -1;
    int         stall_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output monitor: captures handshakes, hold stability, done pulses
    logic       pv = 0, pr = 0, prst = 1;
    logic [7:0] pd = 0;
`ifdef ESP_SEQ_MON_EN
    logic       prxv = 0;
    logic [7:0] prxd = 0;
`endif
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (pv && !pr) begin
                check("hold_valid", tx_valid, 1);
                check("hold_data", tx_data, pd);
            end
            if (rise_wait && tx_valid) begin
                gap_q.push_back(cyc - nl_cyc);
                rise_wait = 0;
            end
            if (tx_valid && tx_ready) begin
                sent.push_back(tx_data);
                if (tx_data == 8'h0A) begin
                    nl_pend++;
                    nl_cyc = cyc;
                    rise_wait = 1;
                end
            end
            if (done) done_cnt++;
        end
`ifdef ESP_SEQ_MON_EN
        if (!prst) begin
            check("mon_valid", mon_valid, prxv);
            if (prxv) check("mon_data", mon_data, prxd);
        end
        prxv = rx_valid;
        prxd = rx_data;
`endif
        pv = tx_valid && !rst;
        pr = tx_ready;
        pd = tx_data;
        prst = rst;
    end

    // TX back-pressure driver
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (force_low) tx_ready = 1'b0;
            else if (stall_at >= 0 && sent.size() == stall_at && tx_valid
                     && stall_cnt < 10) begin
                tx_ready = 1'b0;
                stall_cnt++;
            end else if (rnd_ready) tx_ready = ($urandom_range(0, 2) != 0);
            else tx_ready = 1'b1;
        end
    end

    task automatic send_rx(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        if ($urandom_range(0, 1) != 0) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Modem emulator: one reply (0=OK, 1=ERROR, 2=silent) per command sent
    initial begin
        int r;
        int n;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (nl_pend > 0) begin
                nl_pend--;
                r = 0;
                if (resp_q.size() > 0) r = resp_q.pop_front();
                if (r != 2) begin
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                    if ($urandom_range(0, 1) != 0) begin
                        n = $urandom_range(0, 5);
                        for (int i = 0; i < n; i++)
                            send_rx(8'($urandom_range(65, 78)));
                        send_rx(8'h0D);
                        send_rx(8'h0A);
                    end
                    if (r == 0) begin
                        send_rx(8'h4F); send_rx(8'h4B);
                    end else begin
                        send_rx(8'h45); send_rx(8'h52); send_rx(8'h52);
                        send_rx(8'h4F); send_rx(8'h52);
                    end
                    send_rx(8'h0D);
                    send_rx(8'h0A);
                end
            end
        end
    end

    // Command-level model: each attempt sends the whole command, then
    // consumes one reply; OK advances, else retry up to MR times.
    task automatic model(output int e_done, output int e_err, output int e_idx);
        int a, e, tries, r;
        int dec[$];
        logic [7:0] b;
        dec = resp_q;
        exp_sent.delete();
        e_done = 0; e_err = 0; e_idx = 0;
        a = 0; tries = 0;
        for (int guard = 0; guard < 64; guard++) begin
            if (rom[a] == 8'h00) begin
                e_done = 1;
                return;
            end
            e = a;
            while (1) begin
                b = rom[e];
                exp_sent.push_back(b);
                e++;
                if (b == 8'h0A) break;
            end
            r = 0;
            if (dec.size() > 0) r = dec.pop_front();
            if (r == 0) begin
                e_idx++;
                a = e;
                tries = 0;
            end else if (tries < MR) begin
                tries++;
            end else begin
                e_err = 1;
                return;
            end
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < (1 << AW); i++) rom[i] = 8'h00;
    endtask

    task automatic put_str(input string s, inout int p);
        for (int i = 0; i < s.len(); i++) begin
            rom[p] = s[i];
            p++;
        end
    endtask

    task automatic run_case(input string nm, input bit chk_lat);
        int e_done, e_err, e_idx, n;
        model(e_done, e_err, e_idx);
        sent.delete();
        gap_q.delete();
        done_cnt = 0;
        nl_pend = 0;
        rise_wait = 0;
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (chk_lat) begin
            check({nm, "_busy"}, busy, 1);
            @(posedge clk);
            #1;
            check({nm, "_lat1"}, tx_valid, 0);
            @(posedge clk);
            #1;
            check({nm, "_lat2"}, tx_valid, 1);
        end
        n = 0;
        while (busy && n < 4000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({nm, "_finish"}, (n < 4000), 1);
        check({nm, "_nbytes"}, sent.size(), exp_sent.size());
        for (int i = 0; i < exp_sent.size() && i < sent.size(); i++)
            check({nm, "_byte"}, sent[i], exp_sent[i]);
        check({nm, "_done"}, done_cnt, e_done);
        check({nm, "_error"}, error, e_err);
        check({nm, "_idx"}, cmd_idx, e_idx);
        check({nm, "_idle"}, busy, 0);
    endtask

    initial begin
        int p, n, ncmd, len;
        rst = 1'b1;
        start = 1'b0;
        clear_rom();
        repeat (3) @(posedge clk);
        #1;
        check("rst_rx_ready", rx_ready, 1);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_cmd_idx", cmd_idx, 0);
`ifdef ESP_SEQ_MON_EN
        check("rst_mon_valid", mon_valid, 0);
        check("rst_mon_data", mon_data, 0);
`endif
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_rx_ready", rx_ready, 1);

        // Single command, OK reply
        clear_rom();
        p = 0;
        put_str("AT\r\n", p);
        resp_q = '{0};
        run_case("at_ok", 1);

        // Two commands, first answered ERROR once
        clear_rom();
        p = 0;
        put_str("AT\r\n", p);
        put_str("AT+GMR\r\n", p);
        resp_q = '{1, 0, 0};
        run_case("err_retry", 0);

        // No reply at all: retries exhaust into FAIL
        clear_rom();
        p = 0;
        put_str("AT\r\n", p);
        resp_q = '{2, 2, 2};
        run_case("timeout", 0);
        check("tmo_gaps", gap_q.size(), 2);
        // WAIT_RESP window of TMO cycles, then FETCH and LOAD
        for (int i = 0; i < gap_q.size(); i++)
            check("tmo_gap", gap_q[i], TMO + 3);

        // Back-pressure on the third byte
        clear_rom();
        p = 0;
        put_str("AT\r\n", p);
        resp_q = '{0};
        stall_at = 2;
        stall_cnt = 0;
        run_case("stall", 0);
        check("stall_len", stall_cnt, 10);
        stall_at = -1;

        // Reset in the middle of a handshake, then replay
        clear_rom();
        p = 0;
        put_str("AT\r\n", p);
        force_low = 1;
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (!tx_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("mid_send", tx_valid, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_valid", tx_valid, 0);
        check("mid_rst_addr", rom_addr, 0);
        check("mid_rst_busy", busy, 0);
        rst = 1'b0;
        force_low = 0;
        resp_q = '{0};
        run_case("replay", 0);

        // Randomized scripts, replies and back-pressure
        rnd_ready = 1;
        for (int t = 0; t < 12; t++) begin
            clear_rom();
            p = 0;
            ncmd = $urandom_range(1, 4);
            for (int c = 0; c < ncmd; c++) begin
                len = $urandom_range(2, 6);
                for (int k = 0; k < len; k++) begin
                    rom[p] = 8'($urandom_range(65, 78));
                    p++;
                end
                rom[p] = 8'h0D; p++;
                rom[p] = 8'h0A; p++;
            end
            resp_q.delete();
            for (int k = 0; k < ncmd * (MR + 1); k++) begin
                n = $urandom_range(0, 19);
                resp_q.push_back(n < 12 ? 0 : (n < 17 ? 1 : 2));
            end
            run_case("rand", 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule
